pipe_stage_elastic: RTL

//  Parametrised elastic pipeline stage register for the RV32I core; replaces fixed-enable stage registers.

---
 rtl/rv_pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_stage_elastic.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I elastic pipeline stage registers.
package rv_pipe_pkg;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   // Writeback controls that travel with every pipeline entry
   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic            we;
   } wb_ctrl_t;

   // Head write enable: never asserted on an empty head, optionally masked for x0
   function automatic logic gate_we(input logic we, input logic valid,
                                    input logic rd_nz, input logic zero_rd);
      return we & valid & (rd_nz | ~zero_rd);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: payload, rd, write enable and a valid bit.
// Clear has priority over load so a flush always empties the slot.
module pipe_slot #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [DATA_W-1:0] d_data,
   input  logic [RD_W-1:0]   d_rd,
   input  logic              d_we,
   output logic              valid,
   output logic [DATA_W-1:0] q_data,
   output logic [RD_W-1:0]   q_rd,
   output logic              q_we
);

   // Valid bit and entry contents; contents only change on load
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid  <= 1'b0;
         q_data <= '0;
         q_rd   <= '0;
         q_we   <= 1'b0;
      end else begin
         if (clr)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         if (load) begin
            q_data <= d_data;
            q_rd   <= d_rd;
            q_we   <= d_we;
         end
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register shared by IF/ID, ID/EX, EX/MEM and MEM/WB.
// SKID=1 adds a second entry so in_ready depends only on registered state.
module pipe_stage_elastic #(
   parameter int DATA_W  = rv_pipe_pkg::XLEN,
   parameter int RD_W    = rv_pipe_pkg::RD_W,
   parameter bit SKID    = 1'b1,
   parameter bit ZERO_RD = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_we,
   output logic [1:0]        occupancy
);

   import rv_pipe_pkg::*;

   logic              in_fire;
   logic              out_fire;
   logic              main_v;
   logic              main_load;
   logic              main_clr;
   logic [DATA_W-1:0] main_d_data;
   logic [RD_W-1:0]   main_d_rd;
   logic              main_d_we;
   logic [DATA_W-1:0] main_data;
   logic [RD_W-1:0]   main_rd;
   logic              main_we;
   logic [1:0]        occ_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = main_v & out_ready;

   // Head entry, always present; it drives the outputs
   pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (main_load),
      .clr    (main_clr),
      .d_data (main_d_data),
      .d_rd   (main_d_rd),
      .d_we   (main_d_we),
      .valid  (main_v),
      .q_data (main_data),
      .q_rd   (main_rd),
      .q_we   (main_we)
   );

   generate
      if (SKID) begin : g_skid
         logic              skid_v;
         logic              skid_load;
         logic              skid_clr;
         logic [DATA_W-1:0] skid_data;
         logic [RD_W-1:0]   skid_rd;
         logic              skid_we;

         // Skid entry catches the one input accepted while the head is stalled
         pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
            .clk    (clk),
            .rst    (rst),
            .load   (skid_load),
            .clr    (skid_clr),
            .d_data (in_data),
            .d_rd   (in_rd),
            .d_we   (in_we),
            .valid  (skid_v),
            .q_data (skid_data),
            .q_rd   (skid_rd),
            .q_we   (skid_we)
         );

         // in_ready comes straight from a flop: no path from out_ready
         assign in_ready = rst & ~skid_v;

         // Head refills from skid first (older entry) to keep FIFO order
         assign main_load   = (~main_v & in_fire) | (out_fire & (skid_v | in_fire));
         assign main_clr    = flush | (out_fire & ~skid_v & ~in_fire);
         assign main_d_data = skid_v ? skid_data : in_data;
         assign main_d_rd   = skid_v ? skid_rd   : in_rd;
         assign main_d_we   = skid_v ? skid_we   : in_we;

         assign skid_load = main_v & ~out_ready & in_fire;
         assign skid_clr  = flush | (skid_v & out_ready);
      end else begin : g_single
         // Single entry: accept whenever the head is empty or leaving
         assign in_ready    = rst & (~main_v | out_ready);
         assign main_load   = in_fire;
         assign main_clr    = flush | (out_fire & ~in_fire);
         assign main_d_data = in_data;
         assign main_d_rd   = in_rd;
         assign main_d_we   = in_we;
      end
   endgenerate

   // Entry count: +1 per accepted input, -1 per delivered head, zero on flush
   always_ff @(posedge clk) begin
      if (!rst)
         occ_q <= 2'd0;
      else if (flush)
         occ_q <= 2'd0;
      else
         occ_q <= occ_q + {1'b0, in_fire} - {1'b0, out_fire};
   end

   assign occupancy = occ_q;
   assign out_valid = main_v;
   assign out_data  = main_data;
   assign out_rd    = main_rd;
   assign out_we    = gate_we(main_we, main_v, |main_rd, ZERO_RD);

endmodule
